mcb_port_tester: RTL

Built-in traffic generator and checker for one 32-bit MCB user port in the RAMTester design. It runs in the `clk0`/`rst0` domain produced by the memory clock infrastructure and waits for MCB calibration. It writes `NUM_BURSTS` bursts of LFSR data, reads them back and compares every word. Results go to the host-side FrontPanel wires as pass/fail flags and counters.

---
 rtl/mcb_tester_pkg.sv | 26 ++
 rtl/mcb_lfsr32.sv | 34 +++
 rtl/mcb_port_tester.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcb_tester_pkg.sv
// Shared types and constants for the MCB port tester: FSM states, MCB
// instruction encodings and the 32-bit data LFSR.
package mcb_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_CMD,
        ST_RD_CMD,
        ST_RD_DATA,
        ST_DONE
    } tester_state_e;

    localparam logic [2:0] MCB_CMD_WR = 3'b000;
    localparam logic [2:0] MCB_CMD_RD = 3'b001;

    localparam int LFSR_TAP0 = 31;
    localparam int LFSR_TAP1 = 21;
    localparam int LFSR_TAP2 = 1;
    localparam int LFSR_TAP3 = 0;

    function automatic logic [31:0] lfsr32_next(input logic [31:0] l);
        return {l[30:0], l[LFSR_TAP0] ^ l[LFSR_TAP1] ^ l[LFSR_TAP2] ^ l[LFSR_TAP3]};
    endfunction

endpackage

// File: rtl/mcb_lfsr32.sv
// 32-bit Fibonacci LFSR with synchronous seed load; value_o is the current
// word and advances one step per cycle with step_i.
module mcb_lfsr32
    import mcb_tester_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        step_i,
    output logic [31:0] value_o
);

    logic [31:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i)
            lfsr_d = SEED;
        else if (step_i)
            lfsr_d = lfsr32_next(lfsr_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            lfsr_q <= SEED;
        else
            lfsr_q <= lfsr_d;
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/mcb_port_tester.sv
// Write/readback traffic generator and checker for one 32-bit MCB user port.
// Define MCB_TESTER_ERR_CAPTURE_EN to add first-mismatch capture outputs.
module mcb_port_tester
    import mcb_tester_pkg::*;
#(
    parameter int          BURST_LEN  = 32,
    parameter int          NUM_BURSTS = 1024,
    parameter logic [29:0] BASE_ADDR  = 30'h0,
    parameter logic [31:0] SEED       = 32'h1
) (
    input  logic        clk0,
    input  logic        rst0,
    input  logic        calib_done,
    input  logic        start,
    output logic        p0_cmd_en,
    output logic [2:0]  p0_cmd_instr,
    output logic [5:0]  p0_cmd_bl,
    output logic [29:0] p0_cmd_byte_addr,
    input  logic        p0_cmd_full,
    output logic        p0_wr_en,
    output logic [31:0] p0_wr_data,
    output logic [3:0]  p0_wr_mask,
    input  logic        p0_wr_full,
    output logic        p0_rd_en,
    input  logic [31:0] p0_rd_data,
    input  logic        p0_rd_empty,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [31:0] error_count,
    output logic [15:0] pass_count
`ifdef MCB_TESTER_ERR_CAPTURE_EN
    ,
    output logic [29:0] first_err_addr,
    output logic [31:0] first_err_exp,
    output logic [31:0] first_err_act
`endif
);

    localparam logic [29:0] BURST_BYTES = 30'(BURST_LEN * 4);
    localparam logic [6:0]  LAST_WORD   = 7'(BURST_LEN - 1);
    localparam logic [31:0] LAST_BURST  = 32'(NUM_BURSTS - 1);

    tester_state_e state_q, state_d;
    logic [6:0]  word_cnt_q, word_cnt_d;
    logic [31:0] burst_idx_q, burst_idx_d;
    logic [29:0] burst_addr_q, burst_addr_d;
    logic        cmd_en_q, cmd_en_d;
    logic [2:0]  cmd_instr_q, cmd_instr_d;
    logic [29:0] cmd_addr_q, cmd_addr_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [15:0] pass_cnt_q, pass_cnt_d;

    logic        lfsr_load, wr_step, chk_step;
    logic [31:0] wr_lfsr, chk_lfsr;
    logic        start_pass, pop, mismatch;

    mcb_lfsr32 #(.SEED(SEED)) u_wr_lfsr (
        .clk_i  (clk0),
        .rst_i  (rst0),
        .load_i (lfsr_load),
        .step_i (wr_step),
        .value_o(wr_lfsr)
    );

    mcb_lfsr32 #(.SEED(SEED)) u_chk_lfsr (
        .clk_i  (clk0),
        .rst_i  (rst0),
        .load_i (lfsr_load),
        .step_i (chk_step),
        .value_o(chk_lfsr)
    );

    // Popping is gated by calib_done so a word is never consumed unchecked
    // in the cycle the pass is aborted.
    assign start_pass = (state_q == ST_IDLE) && start && calib_done;
    assign pop        = (state_q == ST_RD_DATA) && calib_done && !p0_rd_empty;
    assign mismatch   = pop && (p0_rd_data != chk_lfsr);

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        burst_idx_d  = burst_idx_q;
        burst_addr_d = burst_addr_q;
        cmd_en_d     = 1'b0;
        cmd_instr_d  = cmd_instr_q;
        cmd_addr_d   = cmd_addr_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        done_d       = done_q;
        fail_d       = fail_q;
        err_cnt_d    = err_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        lfsr_load    = 1'b0;
        wr_step      = 1'b0;
        chk_step     = 1'b0;

        if (mismatch) begin
            fail_d = 1'b1;
            if (err_cnt_q != 32'hFFFF_FFFF)
                err_cnt_d = err_cnt_q + 32'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_pass) begin
                    state_d      = ST_WR_DATA;
                    word_cnt_d   = '0;
                    burst_idx_d  = '0;
                    burst_addr_d = BASE_ADDR;
                    err_cnt_d    = '0;
                    fail_d       = 1'b0;
                    done_d       = 1'b0;
                    lfsr_load    = 1'b1;
                end
            end
            ST_WR_DATA: begin
                if (!p0_wr_full) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = wr_lfsr;
                    wr_step   = 1'b1;
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = '0;
                        state_d    = ST_WR_CMD;
                    end else begin
                        word_cnt_d = word_cnt_q + 7'd1;
                    end
                end
            end
            ST_WR_CMD: begin
                if (!p0_cmd_full) begin
                    cmd_en_d    = 1'b1;
                    cmd_instr_d = MCB_CMD_WR;
                    cmd_addr_d  = burst_addr_q;
                    if (burst_idx_q == LAST_BURST) begin
                        burst_idx_d  = '0;
                        burst_addr_d = BASE_ADDR;
                        state_d      = ST_RD_CMD;
                    end else begin
                        burst_idx_d  = burst_idx_q + 32'd1;
                        burst_addr_d = burst_addr_q + BURST_BYTES;
                        state_d      = ST_WR_DATA;
                    end
                end
            end
            ST_RD_CMD: begin
                if (!p0_cmd_full) begin
                    cmd_en_d    = 1'b1;
                    cmd_instr_d = MCB_CMD_RD;
                    cmd_addr_d  = burst_addr_q;
                    state_d     = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (pop) begin
                    chk_step = 1'b1;
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = '0;
                        if (burst_idx_q == LAST_BURST) begin
                            state_d = ST_DONE;
                        end else begin
                            burst_idx_d  = burst_idx_q + 32'd1;
                            burst_addr_d = burst_addr_q + BURST_BYTES;
                            state_d      = ST_RD_CMD;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + 7'd1;
                    end
                end
            end
            ST_DONE: begin
                done_d     = 1'b1;
                pass_cnt_d = pass_cnt_q + 16'd1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Losing calibration aborts the pass; read data left in the FIFO is
        // deliberately not drained.
        if (state_q != ST_IDLE && !calib_done) begin
            state_d    = ST_IDLE;
            fail_d     = 1'b1;
            done_d     = 1'b0;
            pass_cnt_d = pass_cnt_q;
            cmd_en_d   = 1'b0;
            wr_en_d    = 1'b0;
        end
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            burst_idx_q  <= '0;
            burst_addr_q <= '0;
            cmd_en_q     <= 1'b0;
            cmd_instr_q  <= '0;
            cmd_addr_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            err_cnt_q    <= '0;
            pass_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            burst_idx_q  <= burst_idx_d;
            burst_addr_q <= burst_addr_d;
            cmd_en_q     <= cmd_en_d;
            cmd_instr_q  <= cmd_instr_d;
            cmd_addr_q   <= cmd_addr_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            err_cnt_q    <= err_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
        end
    end

`ifdef MCB_TESTER_ERR_CAPTURE_EN
    logic [29:0] ferr_addr_q;
    logic [31:0] ferr_exp_q, ferr_act_q;

    // fail_q is still low on the first mismatch of a pass.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            ferr_addr_q <= '0;
            ferr_exp_q  <= '0;
            ferr_act_q  <= '0;
        end else if (start_pass) begin
            ferr_addr_q <= '0;
            ferr_exp_q  <= '0;
            ferr_act_q  <= '0;
        end else if (mismatch && !fail_q) begin
            ferr_addr_q <= burst_addr_q + {21'd0, word_cnt_q, 2'b00};
            ferr_exp_q  <= chk_lfsr;
            ferr_act_q  <= p0_rd_data;
        end
    end

    assign first_err_addr = ferr_addr_q;
    assign first_err_exp  = ferr_exp_q;
    assign first_err_act  = ferr_act_q;
`endif

    assign p0_cmd_en        = cmd_en_q;
    assign p0_cmd_instr     = cmd_instr_q;
    assign p0_cmd_bl        = 6'(BURST_LEN - 1);
    assign p0_cmd_byte_addr = cmd_addr_q;
    assign p0_wr_en         = wr_en_q;
    assign p0_wr_data       = wr_data_q;
    assign p0_wr_mask       = 4'h0;
    assign p0_rd_en         = pop;
    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;
    assign fail             = fail_q;
    assign error_count      = err_cnt_q;
    assign pass_count       = pass_cnt_q;

endmodule
